// File: rtl/blk_match_scheduler.sv
// Raster-order block request sequencer for the block matcher. It throttles on
// outstanding matcher results and on free row slots in the downstream xor buffer.
module blk_match_scheduler #(
  parameter int FRAME_W         = 240,
  parameter int FRAME_H         = 240,
  parameter int BLK_W           = 16,
  parameter int BLK_H           = 16,
  parameter int BUF_ROWS        = 6,
  parameter int MAX_OUTSTANDING = 4,
  localparam int COLS = FRAME_W / BLK_W,
  localparam int ROWS = FRAME_H / BLK_H,
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int KW   = $clog2(BUF_ROWS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          req_ready,
  input  logic          result_valid,
  input  logic          row_released,
  output logic          req_valid,
  output logic [CW-1:0] req_blk_col,
  output logic [RW-1:0] req_blk_row,
  output logic          busy,
  output logic          frame_done,
  output logic [KW-1:0] credits,
  output logic          err_result,
  output logic          err_credit
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_O    = OW'(MAX_OUTSTANDING);
  localparam logic [KW-1:0] FULL     = KW'(BUF_ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          row_open_q, row_open_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [KW-1:0] credits_q, credits_d;
  logic          err_result_q, err_result_d;
  logic          err_credit_q, err_credit_d;
  logic          hs, consume, last_blk;

  // All outputs decode registered state only, so no input reaches them combinationally.
  assign req_valid   = (state_q == ISSUE) && (outstanding_q < MAX_O) &&
                       (row_open_q || (credits_q != '0));
  assign req_blk_col = col_q;
  assign req_blk_row = row_q;
  assign busy        = (state_q == ISSUE) || (state_q == DRAIN);
  assign frame_done  = (state_q == DONE);
  assign credits     = credits_q;
  assign err_result  = err_result_q;
  assign err_credit  = err_credit_q;

  assign hs       = req_valid && req_ready;
  assign consume  = hs && !row_open_q;
  assign last_blk = (col_q == COL_LAST) && (row_q == ROW_LAST);

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    row_open_d    = row_open_q;
    outstanding_d = outstanding_q;
    credits_d     = credits_q;
    err_result_d  = err_result_q;
    err_credit_d  = err_credit_q;

    case (state_q)
      IDLE: if (frame_start) begin
        state_d    = ISSUE;
        col_d      = '0;
        row_d      = '0;
        row_open_d = 1'b0;
      end
      ISSUE: if (hs && last_blk) state_d = DRAIN;
      // Registered count is used, so a final result racing the last issue still spends a cycle here.
      DRAIN: if (outstanding_q == '0) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (hs) begin
      row_open_d = 1'b1;
      if (col_q == COL_LAST) begin
        col_d      = '0;
        row_d      = row_q + RW'(1);
        row_open_d = 1'b0;
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    case ({hs, result_valid})
      2'b10: outstanding_d = outstanding_q + OW'(1);
      2'b01: begin
        if (outstanding_q == '0) err_result_d = 1'b1;
        else                     outstanding_d = outstanding_q - OW'(1);
      end
      default: ;
    endcase

    // A release can never push the count above the slot total.
    case ({consume, row_released})
      2'b10: credits_d = credits_q - KW'(1);
      2'b01: begin
        if (credits_q == FULL) err_credit_d = 1'b1;
        else                   credits_d = credits_q + KW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      col_q         <= '0;
      row_q         <= '0;
      row_open_q    <= 1'b0;
      outstanding_q <= '0;
      credits_q     <= FULL;
      err_result_q  <= 1'b0;
      err_credit_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      row_open_q    <= row_open_d;
      outstanding_q <= outstanding_d;
      credits_q     <= credits_d;
      err_result_q  <= err_result_d;
      err_credit_q  <= err_credit_d;
    end
  end

endmodule

// File: tb/tb_blk_match_scheduler.sv
// Directed bench: a 4x3-block frame with 6 row slots (dut) and one with 2 row slots (dut2);
// expected request coordinates are queued at frame start and popped on each handshake.
module tb_blk_match_scheduler;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       frame_start, req_ready, result_valid, row_released;
  logic       req_valid, busy, frame_done, err_result, err_credit;
  logic [1:0] req_blk_col, req_blk_row;
  logic [2:0] credits;

  logic       b_frame_start, b_req_ready, b_result_valid, b_row_released;
  logic       b_req_valid, b_busy, b_frame_done, b_err_result, b_err_credit;
  logic [1:0] b_req_blk_col, b_req_blk_row;
  logic [1:0] b_credits;

  blk_match_scheduler #(
    .FRAME_W(64), .FRAME_H(48), .BLK_W(16), .BLK_H(16), .BUF_ROWS(6), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .req_ready(req_ready),
    .result_valid(result_valid), .row_released(row_released), .req_valid(req_valid),
    .req_blk_col(req_blk_col), .req_blk_row(req_blk_row), .busy(busy),
    .frame_done(frame_done), .credits(credits), .err_result(err_result), .err_credit(err_credit)
  );

  blk_match_scheduler #(
    .FRAME_W(64), .FRAME_H(48), .BLK_W(16), .BLK_H(16), .BUF_ROWS(2), .MAX_OUTSTANDING(4)
  ) dut2 (
    .clk(clk), .reset(reset), .frame_start(b_frame_start), .req_ready(b_req_ready),
    .result_valid(b_result_valid), .row_released(b_row_released), .req_valid(b_req_valid),
    .req_blk_col(b_req_blk_col), .req_blk_row(b_req_blk_row), .busy(b_busy),
    .frame_done(b_frame_done), .credits(b_credits), .err_result(b_err_result),
    .err_credit(b_err_credit)
  );

  int checks = 0;
  int failures = 0;
  int sb[$];
  int sb2[$];
  int n_hs, n_done, tb_out;
  int n2_hs, n2_done, b_out;
  logic hs_t, h0, h1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_frame();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) sb.push_back(r * 16 + c);
  endtask

  task automatic push_frame2();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) sb2.push_back(r * 16 + c);
  endtask

  // One cycle on dut: apply inputs, score any handshake, advance to just after the edge.
  task automatic drive(input logic rdy, input logic res, input logic rel, input logic fs,
                       output logic hs);
    int e;
    req_ready = rdy; result_valid = res; row_released = rel; frame_start = fs;
    hs = req_valid && rdy;
    if (hs) begin
      n_hs++;
      tb_out++;
      chk("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("coord", int'(req_blk_row) * 16 + int'(req_blk_col), e);
      end
    end
    if (res && tb_out > 0) tb_out--;
    @(posedge clk); #1;
    frame_start = 1'b0; result_valid = 1'b0; row_released = 1'b0;
    if (frame_done) n_done++;
  endtask

  task automatic drive2(input logic rdy, input logic res, input logic rel, input logic fs,
                        output logic hs);
    int e;
    b_req_ready = rdy; b_result_valid = res; b_row_released = rel; b_frame_start = fs;
    hs = b_req_valid && rdy;
    if (hs) begin
      n2_hs++;
      b_out++;
      chk("sb2_nonempty", (sb2.size() > 0) ? 1 : 0, 1);
      if (sb2.size() > 0) begin
        e = sb2.pop_front();
        chk("coord2", int'(b_req_blk_row) * 16 + int'(b_req_blk_col), e);
      end
    end
    if (res && b_out > 0) b_out--;
    @(posedge clk); #1;
    b_frame_start = 1'b0; b_result_valid = 1'b0; b_row_released = 1'b0;
    if (b_frame_done) n2_done++;
  endtask

  // Results returned one per cycle while any are owed; freed rows released promptly.
  task automatic run_auto(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, tb_out > 0, credits < 3'd6, 1'b0, hs_t);
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 0; req_ready = 0; result_valid = 0; row_released = 0;
    b_frame_start = 0; b_req_ready = 0; b_result_valid = 0; b_row_released = 0;
    n_hs = 0; n_done = 0; tb_out = 0; n2_hs = 0; n2_done = 0; b_out = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_req_valid", req_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_credits", credits, 6);
    chk("rst_err_result", err_result, 0);
    chk("rst_err_credit", err_credit, 0);
    chk("rst_coords", {req_blk_row, req_blk_col}, 0);

    // Frame with results 2 cycles after issue.
    push_frame();
    h0 = 0; h1 = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, hs_t);
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, h1, credits < 3'd6, 1'b0, hs_t);
      h1 = h0; h0 = hs_t;
    end
    chk("f1_requests", n_hs, 12);
    chk("f1_frame_done", n_done, 1);
    chk("f1_credits", credits, 6);
    chk("f1_busy", busy, 0);
    chk("f1_sb_empty", sb.size(), 0);
    chk("f1_errs", {err_result, err_credit}, 0);

    // Outstanding limit with results withheld.
    n_hs = 0; n_done = 0;
    push_frame();
    drive(1'b1, 1'b0, 1'b0, 1'b1, hs_t);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, credits < 3'd6, 1'b0, hs_t);
    chk("max_out_hs", n_hs, 4);
    chk("max_out_stall", req_valid, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, hs_t);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, credits < 3'd6, 1'b0, hs_t);
    chk("max_out_one_more", n_hs, 5);
    chk("max_out_stall2", req_valid, 0);
    run_auto(40);
    chk("f2_requests", n_hs, 12);
    chk("f2_frame_done", n_done, 1);
    chk("f2_credits", credits, 6);

    // Mid-row stall, then simultaneous handshake/result/release at a row start.
    n_hs = 0; n_done = 0;
    push_frame();
    drive(1'b1, 1'b0, 1'b0, 1'b1, hs_t);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, hs_t);
    chk("f3_credits_row0", credits, 5);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", req_valid, 1);
      chk("stall_coord", {req_blk_row, req_blk_col}, 4'b0011);
      drive(1'b0, 1'b0, 1'b0, 1'b0, hs_t);
    end
    chk("stall_no_hs", n_hs, 3);
    drive(1'b1, 1'b1, 1'b0, 1'b0, hs_t);
    chk("pre_sim_outstanding", dut.outstanding_q, 3);
    chk("pre_sim_credits", credits, 5);
    drive(1'b1, 1'b1, 1'b1, 1'b0, hs_t);
    chk("sim_hs", n_hs, 5);
    chk("sim_outstanding", dut.outstanding_q, 3);
    chk("sim_credits", credits, 5);
    chk("sim_errs", {err_result, err_credit}, 0);
    run_auto(40);
    chk("f3_requests", n_hs, 12);
    chk("f3_frame_done", n_done, 1);
    chk("f3_credits", credits, 6);

    // Error flags in IDLE.
    drive(1'b1, 1'b1, 1'b0, 1'b0, hs_t);
    chk("err_result_set", err_result, 1);
    chk("err_credit_clear", err_credit, 0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, hs_t);
    chk("err_credit_set", err_credit, 1);
    chk("err_credit_credits", credits, 6);
    drive(1'b1, 1'b0, 1'b0, 1'b0, hs_t);
    chk("err_sticky", {err_result, err_credit}, 2'b11);

    // Reset mid-frame.
    n_hs = 0; n_done = 0;
    push_frame();
    drive(1'b1, 1'b0, 1'b0, 1'b1, hs_t);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, hs_t);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete(); tb_out = 0;
    chk("mrst_req_valid", req_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_credits", credits, 6);
    chk("mrst_outstanding", dut.outstanding_q, 0);
    chk("mrst_coords", {req_blk_row, req_blk_col}, 0);
    chk("mrst_errs", {err_result, err_credit}, 0);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, hs_t);
    chk("mrst_no_done", n_done, 0);
    chk("mrst_idle", req_valid, 0);

    // Two-slot buffer without releases.
    push_frame2();
    drive2(1'b1, 1'b0, 1'b0, 1'b1, hs_t);
    for (int i = 0; i < 30; i++) drive2(1'b1, b_out > 0, 1'b0, 1'b0, hs_t);
    chk("cred_hs", n2_hs, 8);
    chk("cred_stall", b_req_valid, 0);
    chk("cred_zero", b_credits, 0);
    chk("cred_busy", b_busy, 1);
    drive2(1'b1, 1'b0, 1'b1, 1'b0, hs_t);
    chk("cred_after_release", b_credits, 1);
    for (int i = 0; i < 30; i++) drive2(1'b1, b_out > 0, 1'b0, 1'b0, hs_t);
    chk("cred_hs_total", n2_hs, 12);
    chk("cred_zero_end", b_credits, 0);
    chk("cred_frame_done", n2_done, 1);
    chk("cred_sb_empty", sb2.size(), 0);
    chk("cred_errs", {b_err_result, b_err_credit}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
